traffic_phase_scheduler: RTL
============================

Name: traffic_phase_scheduler

Overview:
Timed, demand-driven sequencer for a highway/street intersection. It holds highway green by default and grants the street a fixed green window only when a street vehicle sensor or a pedestrian button requests it. Minimum-green, yellow and all-red clearance times are enforced. Light encodings match the existing light driver: 00 Red, 01 Green, 10 Yellow. The block sits between the sensor/button inputs and the lamp outputs.

Parameters:
MIN_GREEN, 20, minimum highway-green dwell in clk cycles (>=1)
STREET_GREEN, 10, street-green duration in clk cycles (>=1)
YELLOW_T, 4, yellow duration for either road (>=1)
ALL_RED_T, 2, all-red clearance after each yellow (>=1)
CNT_W, 8, dwell-timer width; every duration parameter must be <= 2**CNT_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
street_req  in  1  street vehicle sensor, level, sampled each cycle
ped_req  in  1  pedestrian button, single-cycle pulse or level
highway  out  2  highway lamp: 00 Red, 01 Green, 10 Yellow
street  out  2  street lamp, same encoding
walk  out  1  pedestrian walk lamp
ped_pending  out  1  pedestrian request latched, not yet served
phase  out  3  current state code, for debug and observation

Behaviour:
- States and codes: HWY_GREEN=0, HWY_YELLOW=1, ALL_RED_A=2, ST_GREEN=3, ST_YELLOW=4, ALL_RED_B=5. Codes 6 and 7 are illegal; on the next edge they go to HWY_GREEN with the timer reloaded.
- Reset (rst==0 at clk edge):
  - state=HWY_GREEN, timer=MIN_GREEN-1, ped_pending=0, walk_grant=0.
  - Resulting outputs: highway=01, street=00, walk=0.
  - Reset mid-cycle of any state aborts the sequence immediately.
- Dwell timer:
  - Loaded with duration-1 on every state entry.
  - Decrements each cycle and saturates at 0.
  - Each timed state therefore lasts exactly its duration in cycles.
- Transitions:
  - HWY_GREEN -> HWY_YELLOW when timer==0 and (street_req | ped_req | ped_pending). With no demand it stays in HWY_GREEN indefinitely.
  - HWY_YELLOW -> ALL_RED_A after YELLOW_T cycles.
  - ALL_RED_A -> ST_GREEN after ALL_RED_T cycles.
  - ST_GREEN -> ST_YELLOW after STREET_GREEN cycles, whether or not street_req is still high.
  - ST_YELLOW -> ALL_RED_B after YELLOW_T cycles.
  - ALL_RED_B -> HWY_GREEN after ALL_RED_T cycles.
- Lamp decode (combinational from registered state, zero latency):
  - HWY_GREEN: hwy 01 / st 00
  - HWY_YELLOW: 10 / 00
  - ALL_RED_A and ALL_RED_B: 00 / 00
  - ST_GREEN: 00 / 01
  - ST_YELLOW: 00 / 10
- Pedestrian handling:
  - ped_pending sets on ped_req in any state.
  - On the ALL_RED_A -> ST_GREEN transition, walk_grant <= ped_pending | ped_req and ped_pending clears.
  - A ped_req arriving in that same entry cycle is served by the current window and does not re-set ped_pending.
  - walk = walk_grant & (state==ST_GREEN). walk_grant clears on leaving ST_GREEN.
  - A ped_req during ST_GREEN/ST_YELLOW/ALL_RED_B stays latched and forces the next street cycle once MIN_GREEN expires.
- The two roads are never simultaneously non-red, in any state or after reset.

Optional Feature:
Macro: TRAFFIC_EMERG_PREEMPT_EN.
- When defined:
  - Adds input port emerg (1 bit, level).
  - While emerg==1, HWY_GREEN ignores all demand.
  - emerg==1 in ST_GREEN forces ST_YELLOW on the next edge; walk drops with it.
  - All other states complete normally.
  - ped_pending is unaffected by emerg.
- When undefined: no emerg port and no preemption logic.

Decomposition:
- Package traffic_pkg holds:
  - Lamp encoding constants LAMP_RED=2'b00, LAMP_GREEN=2'b01, LAMP_YELLOW=2'b10.
  - The 3-bit state enum/codes.
  - The default duration constants.
- One natural sub-module: phase_timer, a loadable down-counter of width CNT_W with load/value inputs and a done (==0) output, saturating at 0.

Test Plan:
- Defaults, rst low 3 cycles then high, no requests for 200 cycles -> highway=01, street=00, walk=0, phase=0 every cycle.
- street_req held high from reset release (cycle 0) -> HWY_GREEN 0-19, HWY_YELLOW 20-23, ALL_RED_A 24-25, ST_GREEN 26-35, ST_YELLOW 36-39, ALL_RED_B 40-41, HWY_GREEN at 42 with another 20-cycle minimum.
- Idle 50 cycles, ped_req pulse at cycle 50 -> ped_pending=1 at 51, HWY_YELLOW at 51, ST_GREEN 57-66 with walk=1 exactly those 10 cycles, ped_pending=0 from 57.
- ped_req pulse during ST_GREEN of a street_req-only cycle -> walk stays 0 this window; ped_pending=1 persists; next ST_GREEN has walk=1 after MIN_GREEN.
- rst driven low for 1 cycle at ST_GREEN cycle 3 -> next cycle highway=01, street=00, walk=0, ped_pending=0, timer=19.
- With TRAFFIC_EMERG_PREEMPT_EN, emerg=1 at ST_GREEN cycle 2 -> street=10 next cycle; emerg held during HWY_GREEN with street_req=1 -> no exit until emerg=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp encodings, phase codes and default durations for the intersection sequencer
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [2:0] {
    HWY_GREEN  = 3'd0,
    HWY_YELLOW = 3'd1,
    ALL_RED_A  = 3'd2,
    ST_GREEN   = 3'd3,
    ST_YELLOW  = 3'd4,
    ALL_RED_B  = 3'd5
  } phase_t;

  localparam int DEF_MIN_GREEN    = 20;
  localparam int DEF_STREET_GREEN = 10;
  localparam int DEF_YELLOW_T     = 4;
  localparam int DEF_ALL_RED_T    = 2;
  localparam int DEF_CNT_W        = 8;

  // Highway lamp for a phase; anything not explicitly green/yellow shows red.
  function automatic logic [1:0] hwy_lamp(input phase_t p);
    case (p)
      HWY_GREEN:  return LAMP_GREEN;
      HWY_YELLOW: return LAMP_YELLOW;
      default:    return LAMP_RED;
    endcase
  endfunction

  // Street lamp for a phase; anything not explicitly green/yellow shows red.
  function automatic logic [1:0] st_lamp(input phase_t p);
    case (p)
      ST_GREEN:  return LAMP_GREEN;
      ST_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable saturating down-counter used as the phase dwell timer
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Load wins; otherwise count down and hold at zero. The owner asserts load during reset.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-driven highway/street phase sequencer; optional emerg input under TRAFFIC_EMERG_PREEMPT_EN
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN    = DEF_MIN_GREEN,
  parameter int STREET_GREEN = DEF_STREET_GREEN,
  parameter int YELLOW_T     = DEF_YELLOW_T,
  parameter int ALL_RED_T    = DEF_ALL_RED_T,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       street_req,
  input  logic       ped_req,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
  input  logic       emerg,
`endif
  output logic [1:0] highway,
  output logic [1:0] street,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  phase_t           state;
  phase_t           next_state;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;
  logic             walk_grant;
  logic             grant_nxt;
  logic             pend_nxt;
  logic             emerg_i;

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  assign emerg_i = emerg;
`else
  assign emerg_i = 1'b0;
`endif

  // Phase advance: highway green waits for demand after its minimum, every other phase runs its fixed dwell.
  always_comb begin
    next_state = state;
    case (state)
      HWY_GREEN:  if (tmr_done && (street_req || ped_req || ped_pending) && !emerg_i) next_state = HWY_YELLOW;
      HWY_YELLOW: if (tmr_done) next_state = ALL_RED_A;
      ALL_RED_A:  if (tmr_done) next_state = ST_GREEN;
      ST_GREEN:   if (tmr_done || emerg_i) next_state = ST_YELLOW;
      ST_YELLOW:  if (tmr_done) next_state = ALL_RED_B;
      ALL_RED_B:  if (tmr_done) next_state = HWY_GREEN;
      default:    next_state = HWY_GREEN;
    endcase
  end

  // Timer reload on every phase entry (including recovery from an illegal code) and during reset.
  always_comb begin
    tmr_load = !rst || (next_state != state);
    case (next_state)
      HWY_YELLOW, ST_YELLOW: tmr_value = CNT_W'(YELLOW_T - 1);
      ALL_RED_A, ALL_RED_B:  tmr_value = CNT_W'(ALL_RED_T - 1);
      ST_GREEN:              tmr_value = CNT_W'(STREET_GREEN - 1);
      default:               tmr_value = CNT_W'(MIN_GREEN - 1);
    endcase
    if (!rst) tmr_value = CNT_W'(MIN_GREEN - 1);
  end

  // Pedestrian bookkeeping: the entry into street green consumes the latched request plus any same-cycle press.
  always_comb begin
    pend_nxt  = ped_pending | ped_req;
    grant_nxt = walk_grant;
    if (state == ALL_RED_A && next_state == ST_GREEN) begin
      grant_nxt = ped_pending | ped_req;
      pend_nxt  = 1'b0;
    end else if (next_state != ST_GREEN) begin
      grant_nxt = 1'b0;
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Sequencer state with lamps registered from the next phase so they track the state with no lag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= HWY_GREEN;
      ped_pending <= 1'b0;
      walk_grant  <= 1'b0;
      highway     <= LAMP_GREEN;
      street      <= LAMP_RED;
    end else begin
      state       <= next_state;
      ped_pending <= pend_nxt;
      walk_grant  <= grant_nxt;
      highway     <= hwy_lamp(next_state);
      street      <= st_lamp(next_state);
    end
  end

  assign walk  = walk_grant & (state == ST_GREEN);
  assign phase = state;

endmodule
